subtrator_serial: RTL



---
 rtl/subtrator_serial_if.sv | 48 ++++
 rtl/subtrator_serial.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/subtrator_serial_if.sv
// -----------------------------------------------------------------------------
// subtrator_serial_if
// Handshake and data bundle for the bit-serial subtractor.
//   start  : request, sampled by the subtractor only while busy = 0
//   a, b   : WIDTH-bit minuend / subtrahend, captured on the accepting edge
//   bin    : borrow-in, captured on the accepting edge
//   busy   : subtractor is in RUN or DONE
//   done   : one-cycle pulse, diff/borrow valid
//   diff   : registered difference, held until the next done
//   borrow : registered unsigned borrow-out, held with diff
//   ovf    : signed overflow flag (only when SUBTRATOR_SERIAL_OVF_EN is defined)
// Modports: master = controller side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface subtrator_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SUBTRATOR_SERIAL_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow, ovf
   );
`else
   modport master (
      output start, a, b, bin,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, borrow
   );
`endif
endinterface

// File: rtl/subtrator_serial.sv
// -----------------------------------------------------------------------------
// subtrator_serial
// Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, through a single full-subtractor cell and a registered borrow.
// An operation takes WIDTH RUN cycles plus one DONE cycle; the next request
// can be accepted one cycle after DONE (one operation per WIDTH+2 cycles).
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : subtrator_serial_if.slave (start/a/b/bin in, busy/done/diff/
//          borrow[/ovf] out; all outputs registered)
//
// Optional feature: define SUBTRATOR_SERIAL_OVF_EN to add the signed overflow
// flag bus.ovf, registered together with diff.
// -----------------------------------------------------------------------------
module subtrator_serial #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   subtrator_serial_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
   logic             ovf_q;
`endif

   // Full-subtractor cell on bit 0 of the operand shift registers.
   logic             a0;
   logic             b0;
   logic             d;
   logic             br_next;
   logic [WIDTH-1:0] res_next;
   logic             last;

   assign a0      = a_sr[0];
   assign b0      = b_sr[0];
   assign d       = a0 ^ b0 ^ br;
   assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br);

   // New bit enters at the MSB; written via a widened shift so WIDTH=1 works.
   assign res_next = WIDTH'({d, res_sr} >> 1);

   // Counter holds the number of bits already processed.
   assign last = (cnt == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others; reset is sampled
   // synchronously and clears every register, including the shift registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         br       <= 1'b0;
         cnt      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  br     <= bus.bin;
                  res_sr <= '0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end
            end

            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= br_next;
               res_sr <= res_next;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  // Results are published only here, on entry to DONE.
                  state    <= DONE;
                  done_q   <= 1'b1;
                  diff_q   <= res_next;
                  borrow_q <= br_next;
`ifdef SUBTRATOR_SERIAL_OVF_EN
                  // On the last step a0/b0 are the operand MSBs and d is the
                  // result MSB, so no extra copy of the captured MSBs is needed.
                  ovf_q    <= (a0 ^ b0) & (d ^ a0);
`endif
               end
            end

            DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
   assign bus.ovf    = ovf_q;
`endif

endmodule
